f18a_host_bridge: RTL
=====================

// Module: f18a_host_bridge
//
// PURPOSE
//  Upstream host-port stage for the F18A/9918A core. Takes one-cycle decoded Apple II slot
//  accesses, queues them in program order, and replays each as a timed 9918A host cycle
//  (mode, csw_n/csr_n strobe, cd bus). Read data comes back as a pulse. Optionally the block
//  synchronises the VDP interrupt into a maskable IRQ.
//
// PARAMETERS
//  FIFO_DEPTH     4  command queue entries; power of two, >=2
//  STROBE_CYCLES  3  csw_n/csr_n low time in clk_logic_i cycles; >=1
//  GAP_CYCLES     4  minimum idle cycles between strobes; >=0
//
// PORTS
//  clk_logic_i    in   1  single clock for all logic
//  reset_i        in   1  asynchronous, active-high reset
//  req_valid_i    in   1  one-cycle pulse, one per bus access to the VDP window
//  req_rw_i       in   1  1=read, 0=write
//  req_mode_i     in   1  9918A MODE: 0=VRAM data port, 1=register/status port
//  req_data_i     in   8  write data; ignored for reads
//  rd_data_o      out  8  last read result; holds until the next read completes
//  rd_valid_o     out  1  one-cycle pulse when rd_data_o updates
//  busy_o         out  1  FIFO not empty or FSM not IDLE
//  overflow_o     out  1  sticky: a request was dropped because the queue was full
//  ovf_clr_i      in   1  clears overflow_o
//  vdp_mode_o     out  1  to core mode_i
//  vdp_csw_n_o    out  1  to core csw_n_i
//  vdp_csr_n_o    out  1  to core csr_n_i
//  vdp_cd_o       out  8  to core cd_i
//  vdp_cd_i       in   8  from core cd_o
//  vdp_int_n_i    in   1  from core int_n_o
//  irq_en_i       in   1  IRQ mask (1=enabled)
//  irq_o          out  1  active-high interrupt to the host
//
// BEHAVIOUR
//  Reset values (asynchronous, immediate): csw_n/csr_n=1; vdp_mode_o=0; vdp_cd_o=0;
//  rd_data_o=0; rd_valid_o=0; overflow_o=0; irq_o=0. FIFO is emptied and the FSM goes to IDLE.
//  Reset during a strobe ends the strobe immediately and discards the queue.
//  Queue: each entry is {rw, mode, data}. Entries are pushed when req_valid_i=1. Reads and
//  writes share the queue, so the original program order is kept.
//  Full queue: a push is accepted if a pop happens in the same cycle. Otherwise the request
//  is dropped and overflow_o is set. ovf_clr_i and a new overflow in the same cycle: the set wins.
//  FSM:
//   IDLE: if the queue is not empty, pop the head into the command register and go to SETUP.
//   SETUP: 1 cycle. Drive mode and cd (cd=data for writes, 0 for reads). Strobes stay high.
//   STROBE: STROBE_CYCLES cycles with csw_n (write) or csr_n (read) low. Never both low.
//     For a read, vdp_cd_i is sampled on the final strobe cycle.
//   GAP: GAP_CYCLES cycles with both strobes high, then IDLE. GAP_CYCLES=0 goes straight to IDLE.
//  Timing: a request pulsed in cycle N with the queue empty and the FSM in IDLE:
//   - mode/cd are valid from cycle N+2;
//   - the strobe is low for cycles N+3 .. N+2+STROBE_CYCLES;
//   - for a read, rd_valid_o pulses in cycle N+3+STROBE_CYCLES (defaults: N+6).
//  Throughput: one access every 2+STROBE_CYCLES+GAP_CYCLES cycles (defaults: 9).
//  mode and cd stay stable for the whole strobe and are held through GAP.
//  Counters are $clog2(max+1) bits wide and reload on every state entry.
//
// CONFIGURATION
//  F18A_BRIDGE_IRQ_EN defined: vdp_int_n_i passes through a 2-flop synchroniser (reset to 1),
//   and irq_o = ~sync & irq_en_i, registered. irq_o asserts 3 cycles after int_n falls.
//  F18A_BRIDGE_IRQ_EN undefined: irq_o is tied 0, no synchroniser flops are built, and
//   vdp_int_n_i and irq_en_i are unused.
//
// STRUCTURE
//  Package f18a_bridge_pkg: enum state_t {IDLE,SETUP,STROBE,GAP}; struct packed
//   bridge_cmd_t {logic rw; logic mode; logic [7:0] data;}.
//  Sub-module f18a_cmd_fifo: synchronous FIFO of bridge_cmd_t (FIFO_DEPTH) with push, pop,
//   full and empty. The bridge holds the FSM, the counters and the IRQ logic.
//
// TESTING
//  1 Write reg: mode=1 data=0x81, then mode=1 data=0x87 -> csw_n low 3 cycles each,
//    cd=0x81 then 0x87, and rising edges of the two strobes 9 cycles apart.
//  2 Read after writes: W(0x00,m1), W(0x40,m1), R(m0), with the core returning 0x5A ->
//    csr_n asserts only after both csw_n strobes; rd_valid_o fires once with rd_data_o=0x5A.
//  3 Overflow: 6 back-to-back pulses, DEPTH=4 -> 5 accepted (one pop overlaps), 6th dropped,
//    overflow_o=1; ovf_clr_i -> 0.
//  4 Reset mid-strobe: assert reset_i during STROBE cycle 2 -> csw_n=1 the same cycle,
//    busy_o=0, and no further strobes after release.
//  5 Params STROBE_CYCLES=1, GAP_CYCLES=0 -> accesses 3 cycles apart with no overlapping strobes.
//  6 IRQ_EN build: int_n low with irq_en=1 -> irq_o=1 after 3 cycles; irq_en=0 -> irq_o=0.
//    Non-IRQ build -> irq_o always 0.

Source files
------------

// File: rtl/f18a_bridge_pkg.sv
// Shared types for the F18A host bridge: FSM states, queued command format
// and the counter-width helper.
package f18a_bridge_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   typedef struct packed {
      logic       rw;
      logic       mode;
      logic [7:0] data;
   } bridge_cmd_t;

   function automatic int cnt_width(input int s, input int g);
      int m;
      m = (s > g) ? s : g;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/f18a_cmd_fifo.sv
// Command queue for the host bridge; a push into a full queue is only
// accepted when a pop happens in the same cycle.
module f18a_cmd_fifo
   import f18a_bridge_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  bridge_cmd_t data_i,
   input  logic        pop_i,
   output bridge_cmd_t data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   bridge_cmd_t      mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign data_o  = mem_q[rd_q];

   always_comb begin
      wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
      rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/f18a_host_bridge.sv
// Apple II slot to 9918A host-port bridge: queues accesses and replays them
// as timed strobes. Define F18A_BRIDGE_IRQ_EN to build the synchronised IRQ.
module f18a_host_bridge
   import f18a_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int STROBE_CYCLES = 3,
   parameter int GAP_CYCLES    = 4
) (
   input  logic       clk_logic_i,
   input  logic       reset_i,
   input  logic       req_valid_i,
   input  logic       req_rw_i,
   input  logic       req_mode_i,
   input  logic [7:0] req_data_i,
   output logic [7:0] rd_data_o,
   output logic       rd_valid_o,
   output logic       busy_o,
   output logic       overflow_o,
   input  logic       ovf_clr_i,
   output logic       vdp_mode_o,
   output logic       vdp_csw_n_o,
   output logic       vdp_csr_n_o,
   output logic [7:0] vdp_cd_o,
   input  logic [7:0] vdp_cd_i,
   input  logic       vdp_int_n_i,
   input  logic       irq_en_i,
   output logic       irq_o
);

   localparam int CW = cnt_width(STROBE_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0] S_LD = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] G_LD =
      CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   bridge_cmd_t cmd_q, cmd_d, head;
   logic        mode_q, mode_d;
   logic [7:0]  cd_q, cd_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        ovf_q, ovf_d;
   logic        pop, full, empty;

   f18a_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_logic_i),
      .rst_i   (reset_i),
      .push_i  (req_valid_i),
      .data_i  ({req_rw_i, req_mode_i, req_data_i}),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      mode_d     = mode_q;
      cd_d       = cd_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               cmd_d   = head;
               mode_d  = head.mode;
               cd_d    = head.rw ? 8'h00 : head.data;
               cnt_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = S_LD;
            state_d = STROBE;
         end
         STROBE: begin
            if (cnt_q == '0) begin
               // Core read data is captured on the last low cycle.
               if (cmd_q.rw) begin
                  rd_data_d  = vdp_cd_i;
                  rd_valid_d = 1'b1;
               end
               if (GAP_CYCLES > 0) begin
                  cnt_d   = G_LD;
                  state_d = GAP;
               end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr_i) ovf_d = 1'b0;
      if (req_valid_i && full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_logic_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         mode_q     <= 1'b0;
         cd_q       <= 8'h00;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         mode_q     <= mode_d;
         cd_q       <= cd_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign vdp_csw_n_o = ~((state_q == STROBE) & ~cmd_q.rw);
   assign vdp_csr_n_o = ~((state_q == STROBE) & cmd_q.rw);
   assign vdp_mode_o  = mode_q;
   assign vdp_cd_o    = cd_q;
   assign rd_data_o   = rd_data_q;
   assign rd_valid_o  = rd_valid_q;
   assign overflow_o  = ovf_q;
   assign busy_o      = ~empty | (state_q != IDLE);

`ifdef F18A_BRIDGE_IRQ_EN
   logic [1:0] sync_q;
   logic       irq_q;

   always_ff @(posedge clk_logic_i or posedge reset_i) begin
      if (reset_i) begin
         sync_q <= 2'b11;
         irq_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], vdp_int_n_i};
         irq_q  <= ~sync_q[1] & irq_en_i;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_irq;
   assign unused_irq = vdp_int_n_i ^ irq_en_i;
   assign irq_o      = 1'b0;
`endif

endmodule
